// File: rtl/conv_relu_pool.sv
// -----------------------------------------------------------------------------
// conv_relu_pool
//
// Downstream stage of the 3x3 convolution controller. Serial fp16 conv results
// arrive four per 4x4 ifmap tile. Each result optionally goes through ReLU. Each
// group of four is then reduced to one 2x2 max-pool value. Pooled values are
// buffered in a small FIFO that a valid/ready consumer drains.
//
// Build option:
//   CONV_POOL_RELU_EN  defined   -> ReLU (negative -> 16'h0000), unsigned max
//                                   on bits [14:0]
//                      undefined -> no ReLU, signed fp16 max by bit pattern
//
// Parameters:
//   FIFO_DEPTH  pooled-value FIFO entries (power of two, >= 2)
//   GROUP_SIZE  conv results per pooling window (must be 4)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   conv result strobe (controller dout_valid), no backpressure
//   in_data    fp16 conv result
//   conv_done  end-of-layer pulse from the controller
//   out_valid  FIFO non-empty
//   out_data   fp16 pooled value at the FIFO head
//   out_ready  consumer accepts out_data
//   pool_cnt   pooled values pushed since reset (wraps at 2^16)
//   overflow   sticky: a pooled value was dropped because the FIFO was full
//   partial    sticky: conv_done arrived with 1-3 results pending
// -----------------------------------------------------------------------------
module conv_relu_pool #(
    parameter int FIFO_DEPTH = 8,
    parameter int GROUP_SIZE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic        conv_done,
    output logic        out_valid,
    output logic [15:0] out_data,
    input  logic        out_ready,
    output logic [15:0] pool_cnt,
    output logic        overflow,
    output logic        partial
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [1:0] LAST_IDX = 2'(GROUP_SIZE - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    generate
        if (GROUP_SIZE != 4) begin : g_bad_group
            $error("conv_relu_pool: GROUP_SIZE must be 4");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("conv_relu_pool: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    function automatic logic [15:0] reluOf(input logic [15:0] v);
`ifdef CONV_POOL_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    // Max of two fp16 bit patterns. NaN/Inf are ordered purely by their bits.
    function automatic logic [15:0] maxOf(input logic [15:0] a, input logic [15:0] b);
`ifdef CONV_POOL_RELU_EN
        return (b[14:0] > a[14:0]) ? b : a;
`else
        if (a[15] != b[15]) begin
            return a[15] ? b : a;
        end else if (!a[15]) begin
            return (b[14:0] > a[14:0]) ? b : a;
        end else begin
            return (b[14:0] < a[14:0]) ? b : a;
        end
`endif
    endfunction

    // Group accumulation state
    logic [1:0]  grpCnt_q, grpCnt_d;
    logic [15:0] acc_q, acc_d;
    logic        pushValid_q, pushValid_d;
    logic [15:0] pushData_q, pushData_d;
    logic        partial_q, partial_d;

    // FIFO state
    logic [15:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d, rdNext;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      outData_q, outData_d;
    logic [15:0]      poolCnt_q, poolCnt_d;
    logic             overflow_q, overflow_d;

    logic [15:0] inRelu, merged;
    logic        pop, push, full, drop;

    // Accumulate each accepted input. The fourth one produces the pooled value,
    // which is staged one cycle before it reaches the FIFO. The counter wraps on
    // that same edge, so the next group can start with no gap.
    // conv_done is evaluated after the current input is folded in. A group that
    // just completed therefore leaves nothing pending, and no partial is flagged.
    always_comb begin
        inRelu      = reluOf(in_data);
        merged      = (grpCnt_q == 2'd0) ? inRelu : maxOf(acc_q, inRelu);
        grpCnt_d    = grpCnt_q;
        acc_d       = acc_q;
        pushValid_d = 1'b0;
        pushData_d  = pushData_q;
        partial_d   = partial_q;
        if (in_valid) begin
            acc_d = merged;
            if (grpCnt_q == LAST_IDX) begin
                grpCnt_d    = 2'd0;
                pushValid_d = 1'b1;
                pushData_d  = merged;
            end else begin
                grpCnt_d = grpCnt_q + 2'd1;
            end
        end
        if (conv_done && grpCnt_d != 2'd0) begin
            grpCnt_d  = 2'd0;
            partial_d = 1'b1;
        end
    end

    // FIFO control. A push into a full FIFO is still accepted when a pop happens
    // in the same cycle. The head register is refilled from storage, or from the
    // incoming value when the FIFO is about to be empty. When the FIFO drains,
    // the head register keeps the last value.
    always_comb begin
        pop        = (count_q != '0) && out_ready;
        full       = (count_q == FULL_CNT);
        push       = pushValid_q && (!full || pop);
        drop       = pushValid_q && full && !pop;
        rdNext     = rdPtr_q + 1'b1;
        rdPtr_d    = pop ? rdNext : rdPtr_q;
        wrPtr_d    = push ? wrPtr_q + 1'b1 : wrPtr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + ONE_CNT;
        end else if (pop && !push) begin
            count_d = count_q - ONE_CNT;
        end
        outData_d  = outData_q;
        if (pop && count_q > ONE_CNT) begin
            outData_d = mem[rdNext];
        end else if (push && (count_q == '0 || (pop && count_q == ONE_CNT))) begin
            outData_d = pushData_q;
        end
        poolCnt_d  = push ? poolCnt_q + 16'd1 : poolCnt_q;
        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grpCnt_q    <= 2'd0;
            acc_q       <= 16'h0000;
            pushValid_q <= 1'b0;
            pushData_q  <= 16'h0000;
            partial_q   <= 1'b0;
            rdPtr_q     <= '0;
            wrPtr_q     <= '0;
            count_q     <= '0;
            outData_q   <= 16'h0000;
            poolCnt_q   <= 16'h0000;
            overflow_q  <= 1'b0;
        end else begin
            grpCnt_q    <= grpCnt_d;
            acc_q       <= acc_d;
            pushValid_q <= pushValid_d;
            pushData_q  <= pushData_d;
            partial_q   <= partial_d;
            rdPtr_q     <= rdPtr_d;
            wrPtr_q     <= wrPtr_d;
            count_q     <= count_d;
            outData_q   <= outData_d;
            poolCnt_q   <= poolCnt_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage needs no reset; only entries covered by count_q are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr_q] <= pushData_q;
        end
    end

    assign out_valid = (count_q != '0);
    assign out_data  = outData_q;
    assign pool_cnt  = poolCnt_q;
    assign overflow  = overflow_q;
    assign partial   = partial_q;

endmodule

// File: doc/conv_relu_pool.md
Name: conv_relu_pool

Overview:
- Downstream stage of the 3x3 convolution controller.
- Consumes the serial fp16 conv results, four per 4x4 ifmap tile, marked by the controller's `dout_valid`.
- Applies ReLU, then reduces each group of four to one 2x2 max-pool value.
- Buffers pooled values in a small FIFO drained by a valid/ready consumer: writeback DMA or the next layer's feeder.

Parameters:
- FIFO_DEPTH, 8, pooled-value FIFO entries; power of two, minimum 2.
- GROUP_SIZE, 4, conv results per pooling window; fixed at 4, checked by elaboration assertion.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  conv result strobe; driven by the controller's `dout_valid`.
- in_data  input  16  fp16 conv result.
- conv_done  input  1  end-of-layer pulse from the controller's `done`.
- out_valid  output  1  FIFO non-empty.
- out_data  output  16  fp16 pooled value at the FIFO head.
- out_ready  input  1  consumer accepts `out_data`.
- pool_cnt  output  16  pooled values pushed since reset; wraps at 2^16.
- overflow  output  1  sticky: a pooled value was dropped because the FIFO was full.
- partial  output  1  sticky: `conv_done` arrived with 1-3 results pending.

Behaviour:
- Reset (asynchronous, any time, including mid-group):
  - `out_valid`=0, `out_data`=0, `pool_cnt`=0, `overflow`=0, `partial`=0.
  - Group counter=0, accumulator=0, FIFO emptied.
- Input side has no backpressure: every cycle with `in_valid`=1 is accepted.
- ReLU (with macro): sign bit set → value forced to 16'h0000. Covers -0, negative normals and negative NaN.
- Max compare after ReLU: unsigned compare on bits [14:0]. Positive NaN/Inf compare largest and pass through unchanged.
- Group accumulation:
  - Group counter 0..3 advances on each accepted input.
  - At count 0 the accumulator loads the (ReLU'd) input; otherwise accumulator = max(accumulator, input).
- Push:
  - Input accepted at count 3 on edge N → pooled value (max of all four) pushed at edge N+1.
  - `out_valid` is high after edge N+1 (one-cycle latency, registered).
  - Counter returns to 0 at edge N, so back-to-back groups run with no bubbles.
- FIFO:
  - Registered head; `out_data` holds its value while `out_valid`=1 and `out_ready`=0.
  - Pop when `out_valid` && `out_ready`.
  - Full with a simultaneous pop and push: push accepted, occupancy unchanged.
  - Full with no pop: pushed value dropped, `overflow` set, `pool_cnt` not incremented.
  - Empty: `out_ready` ignored, `out_data` holds its last value.
- `pool_cnt` increments on every successful push.
- `conv_done` pulse:
  - Counter≠0: pending group discarded, `partial` set, counter→0.
  - Counter=0: no effect.
  - Simultaneous with `in_valid` at count 3: the group completes and pushes normally, no `partial`.
  - Simultaneous with `in_valid` at count 0-2: the input is included, then the group is discarded.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: CONV_POOL_RELU_EN.
- Defined: ReLU applied as above; compare is unsigned on [14:0].
- Undefined: no ReLU; signed fp16 max.
  - Signs differ: the positive operand wins, and +0 beats -0.
  - Both positive: larger magnitude wins.
  - Both negative: smaller magnitude wins.
  - NaN is treated by bit pattern, as for Inf.
- Latency, FIFO behaviour and flags are identical in both builds.

Test Plan:
1. Reset, then a group 3C00, 4000, 3800, 4200 (1.0, 2.0, 0.5, 3.0) on consecutive cycles → `out_data`=4200, `out_valid` high one cycle after the 4th input, `pool_cnt`=1.
2. ReLU build, group BC00, C000, 8000, B800 (all negative) → 0000. Non-ReLU build, same group → 8000 (-0 is the max).
3. 30 back-to-back groups with `out_ready`=1, matched against golden maxima → 30 correct pops in order, no bubbles, `overflow`=0, `pool_cnt`=30.
4. `out_ready`=0, push 9 groups with FIFO_DEPTH=8 → 8 entries retained, `overflow`=1, `pool_cnt`=8. Then drain → the first 8 values in order, `out_valid` drops after the 8th pop.
5. Two inputs then `conv_done` → no push, `partial`=1. The next four inputs form a fresh group, pushed correctly.
6. Assert `rst_n` low mid-group (after 3 inputs) with the FIFO holding 2 entries → all outputs zero immediately. After release, a new group of 4 → exactly one push with the correct max.
